led_sequencer: RTL and testbench

Programmable LED pattern sequencer that owns the board LEDs and steps them through a selected pattern at a configurable rate derived from CLOCK_50. It generalises the fixed 1 Hz two-LED blinker into a configurable scheduler. Configuration arrives over a valid/ready handshake from a control source such as a key decoder or register block. Configuration changes are applied glitch-free at pattern-step boundaries.

---
 rtl/led_seq_pkg.sv | 38 +++
 rtl/led_sequencer_if.sv | 13 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/led_sequencer.sv | 136 +++++++++++++
 tb/tb_led_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings and LED pattern generator for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ALT   = 2'd1,
        MODE_BOTH  = 2'd2,
        MODE_CHASE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    localparam int unsigned MAX_LED = 32;

    // Bits at or above n_led are always zero so callers can simply truncate.
    function automatic logic [MAX_LED-1:0] pattern(input mode_e mode,
                                                   input int unsigned phase,
                                                   input int unsigned n_led);
        logic [MAX_LED-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_LED; i++) begin
            if (i < n_led) begin
                case (mode)
                    MODE_ALT:   p[i] = ((i % 2) == (phase % 2));
                    MODE_BOTH:  p[i] = ((phase % 2) == 0);
                    MODE_CHASE: p[i] = (i == phase);
                    default:    p[i] = 1'b0;
                endcase
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Configuration handshake bundle between a control source and the LED sequencer.
interface led_sequencer_if;
    import led_seq_pkg::*;

    logic       CFG_VALID;
    logic       CFG_READY;
    mode_e      CFG_MODE;
    logic [2:0] CFG_DIV;

    modport master (output CFG_VALID, output CFG_MODE, output CFG_DIV, input CFG_READY);
    modport slave  (input CFG_VALID, input CFG_MODE, input CFG_DIV, output CFG_READY);

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..BASE_TICKS-1 counter with enable and clear; tick marks the terminal count.
module tick_prescaler #(
    parameter int unsigned BASE_TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(BASE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Steps the board LEDs through a selected pattern; new configuration is taken
// immediately when idle/paused and deferred to the next step boundary while running.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 50_000_000,
    parameter int unsigned N_LED      = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    led_sequencer_if.slave   cfg,
    input  logic             ENABLE,
    output logic [N_LED-1:0] LED,
    output logic             STEP
);

    localparam int unsigned PHASE_W = $clog2(N_LED);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d, pmode_q, pmode_d;
    logic [2:0]         div_q, div_d, divcnt_q, divcnt_d, pdiv_q, pdiv_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pend_q, pend_d;
    logic [N_LED-1:0]   led_q, led_d, pat_next;
    logic               step_q, step_d;
    logic               upd, xfer, boundary, pre_en, pre_clr, pre_tick;

    tick_prescaler #(.BASE_TICKS(BASE_TICKS)) u_pre (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (pre_tick)
    );

    assign pre_en        = (state_q == S_RUN);
    assign cfg.CFG_READY = (state_q == S_RUN) ? !pend_q : 1'b1;
    assign xfer          = cfg.CFG_VALID && cfg.CFG_READY;
    assign boundary      = pre_tick && (divcnt_q == div_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        divcnt_d = divcnt_q;
        phase_d  = phase_q;
        pend_d   = pend_q;
        pmode_d  = pmode_q;
        pdiv_d   = pdiv_q;
        step_d   = 1'b0;
        upd      = 1'b0;
        pre_clr  = 1'b0;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (xfer) begin
                    mode_d   = cfg.CFG_MODE;
                    div_d    = cfg.CFG_DIV;
                    phase_d  = '0;
                    divcnt_d = '0;
                    pend_d   = 1'b0;
                    pre_clr  = 1'b1;
                    upd      = 1'b1;
                    if (cfg.CFG_MODE == MODE_OFF) state_d = S_IDLE;
                    else if (state_q == S_IDLE)   state_d = S_RUN;
                end else if (state_q == S_PAUSE && ENABLE) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    step_d   = 1'b1;
                    upd      = 1'b1;
                    divcnt_d = '0;
                    if (pend_q) begin
                        // A deferred config replaces the phase advance at this boundary.
                        mode_d  = pmode_q;
                        div_d   = pdiv_q;
                        phase_d = '0;
                        pend_d  = 1'b0;
                        pre_clr = 1'b1;
                    end else if (mode_q == MODE_CHASE) begin
                        phase_d = (phase_q == PHASE_W'(N_LED - 1)) ? '0 : phase_q + PHASE_W'(1);
                    end else begin
                        phase_d    = '0;
                        phase_d[0] = ~phase_q[0];
                    end
                end else if (pre_tick) begin
                    divcnt_d = divcnt_q + 3'd1;
                end
                if (xfer) begin
                    pend_d  = 1'b1;
                    pmode_d = cfg.CFG_MODE;
                    pdiv_d  = cfg.CFG_DIV;
                end
                if (mode_d == MODE_OFF) state_d = S_IDLE;
                else if (!ENABLE)       state_d = S_PAUSE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pat_next = N_LED'(pattern(mode_d, 32'(phase_d), N_LED));
    assign led_d    = upd ? pat_next : led_q;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_OFF;
            div_q    <= '0;
            divcnt_q <= '0;
            phase_q  <= '0;
            pend_q   <= 1'b0;
            led_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            divcnt_q <= divcnt_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            led_q    <= led_d;
            step_q   <= step_d;
        end
    end

    // Pending payload is only meaningful while pend_q is set.
    always_ff @(posedge CLOCK_50) begin
        pmode_q <= pmode_d;
        pdiv_q  <= pdiv_d;
    end

    assign LED  = led_q;
    assign STEP = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with BASE_TICKS=4, one 2-LED and one 4-LED instance.
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] led2;
    logic [3:0] led4;
    logic       step2, step4;
    logic [1:0] exp2;
    logic [3:0] exp4;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    led_sequencer_if if2();
    led_sequencer_if if4();

    led_sequencer #(.BASE_TICKS(4), .N_LED(2)) dut2 (
        .CLOCK_50 (clk), .RESET_N (rst_n), .cfg (if2),
        .ENABLE (enable), .LED (led2), .STEP (step2)
    );

    led_sequencer #(.BASE_TICKS(4), .N_LED(4)) dut4 (
        .CLOCK_50 (clk), .RESET_N (rst_n), .cfg (if4),
        .ENABLE (enable), .LED (led4), .STEP (step4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_ALT; if2.CFG_DIV = 3'd0;
        if4.CFG_VALID = 1'b0; if4.CFG_MODE = MODE_OFF; if4.CFG_DIV = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (led2 !== 2'b00) begin errors++; $display("FAIL reset_led: got %b want 00", led2); end
            checks++; if (if2.CFG_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if2.CFG_READY); end
            checks++; if (step2 !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", step2); end
        end
        rst_n = 1'b1;
        if2.CFG_VALID = 1'b0;
        cyc();
        checks++; if (led2 !== 2'b00) begin errors++; $display("FAIL reset_no_cfg_led: got %b want 00", led2); end
        checks++; if (led4 !== 4'b0000) begin errors++; $display("FAIL reset_led4: got %b want 0000", led4); end
    endtask

    task automatic test_chase();
        if4.CFG_VALID = 1'b1; if4.CFG_MODE = MODE_CHASE; if4.CFG_DIV = 3'd1;
        cyc();
        if4.CFG_VALID = 1'b0;
        exp4 = 4'b0001;
        checks++; if (led4 !== exp4) begin errors++; $display("FAIL chase_load_led: got %b want %b", led4, exp4); end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 7; c++) begin
                cyc();
                checks++; if (step4 !== 1'b0 || led4 !== exp4) begin errors++; $display("FAIL chase_hold s%0d c%0d: got step=%b led=%b want step=0 led=%b", s, c, step4, led4, exp4); end
            end
            cyc();
            exp4 = {exp4[2:0], exp4[3]};
            checks++; if (step4 !== 1'b1 || led4 !== exp4) begin errors++; $display("FAIL chase_step s%0d: got step=%b led=%b want step=1 led=%b", s, step4, led4, exp4); end
        end
    endtask

    task automatic test_idle_load();
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_ALT; if2.CFG_DIV = 3'd0;
        cyc();
        if2.CFG_VALID = 1'b0;
        exp2 = 2'b01;
        checks++; if (led2 !== exp2 || step2 !== 1'b0) begin errors++; $display("FAIL idle_load_led: got led=%b step=%b want led=01 step=0", led2, step2); end
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++; if (step2 !== 1'b0 || led2 !== exp2) begin errors++; $display("FAIL alt_hold s%0d c%0d: got step=%b led=%b want step=0 led=%b", s, c, step2, led2, exp2); end
            end
            cyc();
            exp2 = ~exp2;
            checks++; if (step2 !== 1'b1 || led2 !== exp2) begin errors++; $display("FAIL alt_step s%0d: got step=%b led=%b want step=1 led=%b", s, step2, led2, exp2); end
        end
    endtask

    task automatic test_reconfig_run();
        checks++; if (if2.CFG_READY !== 1'b1) begin errors++; $display("FAIL reconfig_ready_before: got %b want 1", if2.CFG_READY); end
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_BOTH; if2.CFG_DIV = 3'd0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if2.CFG_VALID = 1'b0;
            checks++; if (if2.CFG_READY !== 1'b0 || led2 !== 2'b01 || step2 !== 1'b0) begin errors++; $display("FAIL reconfig_pending c%0d: got ready=%b led=%b step=%b want ready=0 led=01 step=0", c, if2.CFG_READY, led2, step2); end
        end
        cyc();
        checks++; if (led2 !== 2'b11 || step2 !== 1'b1) begin errors++; $display("FAIL reconfig_apply: got led=%b step=%b want led=11 step=1", led2, step2); end
        cyc();
        checks++; if (if2.CFG_READY !== 1'b1 || led2 !== 2'b11 || step2 !== 1'b0) begin errors++; $display("FAIL reconfig_after: got ready=%b led=%b step=%b want ready=1 led=11 step=0", if2.CFG_READY, led2, step2); end
    endtask

    task automatic test_pause();
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++; if (led2 !== 2'b11 || step2 !== 1'b0 || if2.CFG_READY !== 1'b1) begin errors++; $display("FAIL pause_hold c%0d: got led=%b step=%b ready=%b want led=11 step=0 ready=1", c, led2, step2, if2.CFG_READY); end
        end
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            checks++; if (step2 !== 1'b0 || led2 !== 2'b11) begin errors++; $display("FAIL resume_wait c%0d: got step=%b led=%b want step=0 led=11", c, step2, led2); end
        end
        cyc();
        checks++; if (step2 !== 1'b1 || led2 !== 2'b00) begin errors++; $display("FAIL resume_step: got step=%b led=%b want step=1 led=00", step2, led2); end
    endtask

    task automatic test_reset_mid_run();
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_ALT; if2.CFG_DIV = 3'd0;
        cyc();
        if2.CFG_VALID = 1'b0;
        checks++; if (if2.CFG_READY !== 1'b0) begin errors++; $display("FAIL midrun_pending_ready: got %b want 0", if2.CFG_READY); end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++; if (led2 !== 2'b00 || if2.CFG_READY !== 1'b1 || step2 !== 1'b0) begin errors++; $display("FAIL midrun_reset: got led=%b ready=%b step=%b want led=00 ready=1 step=0", led2, if2.CFG_READY, step2); end
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++; if (led2 !== 2'b00 || step2 !== 1'b0 || if2.CFG_READY !== 1'b1) begin errors++; $display("FAIL midrun_idle c%0d: got led=%b step=%b ready=%b want led=00 step=0 ready=1", c, led2, step2, if2.CFG_READY); end
        end
    endtask

    task automatic test_back_to_back();
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_ALT; if2.CFG_DIV = 3'd0;
        cyc();
        if2.CFG_VALID = 1'b0;
        checks++; if (led2 !== 2'b01) begin errors++; $display("FAIL b2b_load: got %b want 01", led2); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (step2 !== 1'b0 || led2 !== 2'b01) begin errors++; $display("FAIL b2b_hold1 c%0d: got step=%b led=%b want step=0 led=01", c, step2, led2); end
        end
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_BOTH; if2.CFG_DIV = 3'd0;
        cyc();
        if2.CFG_VALID = 1'b0;
        checks++; if (step2 !== 1'b1 || led2 !== 2'b10 || if2.CFG_READY !== 1'b0) begin errors++; $display("FAIL b2b_edge_accept: got step=%b led=%b ready=%b want step=1 led=10 ready=0", step2, led2, if2.CFG_READY); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (step2 !== 1'b0 || led2 !== 2'b10 || if2.CFG_READY !== 1'b0) begin errors++; $display("FAIL b2b_hold2 c%0d: got step=%b led=%b ready=%b want step=0 led=10 ready=0", c, step2, led2, if2.CFG_READY); end
        end
        cyc();
        checks++; if (step2 !== 1'b1 || led2 !== 2'b11) begin errors++; $display("FAIL b2b_apply_both: got step=%b led=%b want step=1 led=11", step2, led2); end
        if2.CFG_VALID = 1'b1; if2.CFG_MODE = MODE_OFF; if2.CFG_DIV = 3'd0;
        cyc();
        if2.CFG_VALID = 1'b0;
        checks++; if (if2.CFG_READY !== 1'b0 || led2 !== 2'b11) begin errors++; $display("FAIL b2b_off_pending: got ready=%b led=%b want ready=0 led=11", if2.CFG_READY, led2); end
        for (int c = 0; c < 2; c++) begin
            cyc();
            checks++; if (step2 !== 1'b0 || led2 !== 2'b11) begin errors++; $display("FAIL b2b_hold3 c%0d: got step=%b led=%b want step=0 led=11", c, step2, led2); end
        end
        cyc();
        checks++; if (step2 !== 1'b1 || led2 !== 2'b00) begin errors++; $display("FAIL b2b_off_apply: got step=%b led=%b want step=1 led=00", step2, led2); end
        for (int c = 0; c < 4; c++) begin
            cyc();
            checks++; if (step2 !== 1'b0 || led2 !== 2'b00 || if2.CFG_READY !== 1'b1) begin errors++; $display("FAIL b2b_idle c%0d: got step=%b led=%b ready=%b want step=0 led=00 ready=1", c, step2, led2, if2.CFG_READY); end
        end
    endtask

    initial begin
        test_reset();
        test_chase();
        test_idle_load();
        test_reconfig_run();
        test_pause();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
